rd_req_arbiter: RTL and testbench
=================================

# rd_req_arbiter

Per-master-port read arbiter of the cross bar, sitting directly downstream of the read request FIFOs (one per base slave port) that the read request handlers fill. It takes FIFO heads whose one-hot `wren` targets this master port, picks one round-robin, issues it on the base master read port, and pops the winning FIFO on acceptance. It routes the read response back to the originating slave side, with a timeout error path. One instance exists per base master port; the top level ORs the `rd_en` outputs of all instances per FIFO.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, read data width
- `SLAVE_NUM`, 2, number of request FIFOs (base slave ports)
- `MASTER_NUM`, 2, width of `wren`
- `MASTER_IDX`, 0, index of the master port this instance serves
- `TIMEOUT`, 256, max cycles waiting for read data; 0 disables timeout

- `aclk` in 1: clock, all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `req` in SLAVE_NUM: FIFO not-empty, per slave
- `addr` in SLAVE_NUM*AWIDTH: FIFO head address, slave i at [i*AWIDTH +: AWIDTH]
- `wren` in SLAVE_NUM*MASTER_NUM: FIFO head one-hot target, slave i at [i*MASTER_NUM +: MASTER_NUM]
- `rd_en` out SLAVE_NUM: FIFO pop, one-cycle pulse
- `m_req` out 1: read request valid on base master port
- `m_addr` out AWIDTH: read address
- `m_ack` in 1: base master accepted request
- `m_rvalid` in 1: read data valid
- `m_rdata` in DWIDTH: read data
- `resp_valid` out 1: response pulse to slave side
- `resp_sel` out SLAVE_NUM: one-hot originating slave
- `resp_data` out DWIDTH: response data
- `resp_err` out 1: response is timeout error

## Operation
- Eligible[i] = `req[i]` && `wren[i][MASTER_IDX]`. A head targeting another master is never eligible here and never popped here.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any eligible, grant = first eligible after `last_grant` (cyclic). Latch grant index and `addr[grant]`, set `last_grant` = grant, go to ISSUE. Otherwise stay.
  - ISSUE: `m_req`=1, `m_addr` = latched address, both stable until `m_ack`. On `m_ack`: `rd_en[grant]`=1 in that same cycle (combinational), clear timeout counter, go to WAIT.
  - WAIT: `m_rvalid` ignored in any other state. On `m_rvalid`: register `resp_valid`=1, `resp_sel`=onehot(grant), `resp_data`=`m_rdata`, `resp_err`=0, go to IDLE. Else if TIMEOUT≠0 and counter = TIMEOUT-1: `resp_valid`=1, `resp_err`=1, `resp_data`=0, go to IDLE. `m_rvalid` in the same cycle as expiry wins (normal response).
- Counter width $clog2(TIMEOUT+1), saturates, counts only in WAIT.
- Only one outstanding read per instance. At most one `rd_en` bit is high at a time.
- Reset values: state IDLE, `last_grant` = SLAVE_NUM-1 (slave 0 wins first), `m_req`=0, `m_addr`=0, `rd_en`=0, `resp_valid`=0, `resp_sel`=0, `resp_data`=0, `resp_err`=0, counter 0.
- Reset mid-operation: return to IDLE with no pop. An un-acked request stays in its FIFO. A request acked before reset is dropped without a response.

## Timing
- Eligible in IDLE at cycle N: `m_req` high at N+1.
- `m_ack` at cycle A: `rd_en` pulse at A, WAIT from A+1. The FIFO head changes at A+1.
- `m_rvalid` at cycle R: `resp_*` valid at R+1 for exactly one cycle, IDLE at R+1. The next arbitration is at R+1, and the next `m_req` at R+2.
- Timeout: with `m_ack` at A and no data, the error response is valid at A+TIMEOUT+1.
- `resp_sel`/`resp_data`/`resp_err` hold their last values while `resp_valid`=0. `resp_sel` is 0 after reset.

## Structure
- Shared package `xbar_pkg`: `rd_arb_state_t` enum {IDLE, ISSUE, WAIT}, index-width helper (`$clog2` of SLAVE_NUM).
- Sub-module `rr_pick`: combinational round-robin picker, inputs eligible vector and `last_grant`, outputs grant index and found flag. It is reused by the write arbiter.

## Test plan
- Single request, MASTER_IDX=0, slave 1 `req`=1, wren=2'b01, addr=0x1000, `m_ack` at 2nd `m_req` cycle, `m_rvalid` data 0xDEADBEEF after 3 cycles -> `m_addr`=0x1000, exactly one `rd_en`=2'b10 in the ack cycle, `resp_sel`=2'b10, data 0xDEADBEEF, `resp_err`=0.
- Both slaves continuously eligible, immediate ack/rvalid -> grant order 0,1,0,1. No cycle ever has both `rd_en` bits high.
- Slave 0 head wren=2'b10, slave 1 wren=2'b01 -> only slave 1 served, `rd_en[0]` never asserted, `m_addr` = slave 1 address.
- TIMEOUT=8, ack then no `m_rvalid` -> `resp_valid` with `resp_err`=1, data 0, 9 cycles after ack. Then back to IDLE and serving the next request.
- `m_rvalid` coincident with the timeout-expiry cycle -> normal response, `resp_err`=0.
- `reset` asserted in ISSUE before ack -> no `rd_en`, all outputs at reset values next cycle. After release, the same head is reissued with the same address.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared cross-bar definitions.
//   rd_arb_state_t : read arbiter FSM states
//   idx_w()        : bit width needed to index n items (minimum 1)
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_req_arbiter_rr_pick.sv
// Combinational round-robin picker, shared by the read and write arbiters.
// Searches cyclically starting at the entry just after last_i.
//   elig_i  [N]  : eligible requesters
//   last_i  [IW] : index granted last time
//   grant_o [IW] : first eligible index after last_i (0 when none)
//   found_o      : at least one requester is eligible
module rr_pick
  import xbar_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          found_o
);

  int unsigned idx;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_i) + k) % N;
      if (!found_o && elig_i[IW'(idx)]) begin
        found_o = 1'b1;
        grant_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rd_req_arbiter.sv
// Per-master-port read arbiter. Picks one read request FIFO head targeting
// this master port (round-robin), issues it on the base master read port,
// pops the winning FIFO on acceptance and routes the response (or a timeout
// error) back to the originating slave side. One outstanding read at a time.
//   aclk, reset          : clock, synchronous active-high reset
//   req/addr/wren        : FIFO heads (not-empty, address, one-hot target)
//   rd_en                : FIFO pop pulse (combinational with m_ack)
//   m_req/m_addr/m_ack   : base master read request handshake
//   m_rvalid/m_rdata     : base master read data
//   resp_valid/sel/data/err : registered response pulse to the slave side
module rd_req_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned SLAVE_NUM  = 2,
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned MASTER_IDX = 0,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic [SLAVE_NUM-1:0]            req,
  input  logic [SLAVE_NUM*AWIDTH-1:0]     addr,
  input  logic [SLAVE_NUM*MASTER_NUM-1:0] wren,
  output logic [SLAVE_NUM-1:0]            rd_en,
  output logic                            m_req,
  output logic [AWIDTH-1:0]               m_addr,
  input  logic                            m_ack,
  input  logic                            m_rvalid,
  input  logic [DWIDTH-1:0]               m_rdata,
  output logic                            resp_valid,
  output logic [SLAVE_NUM-1:0]            resp_sel,
  output logic [DWIDTH-1:0]               resp_data,
  output logic                            resp_err
);

  localparam int unsigned IW = idx_w(SLAVE_NUM);
  // Counter is at least 1 bit wide so TIMEOUT=0 still elaborates.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  rd_arb_state_t state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [AWIDTH-1:0]    addr_q, addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [SLAVE_NUM-1:0] resp_sel_q, resp_sel_d;
  logic [DWIDTH-1:0]    resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;

  logic [SLAVE_NUM-1:0] elig;
  logic [AWIDTH-1:0]    addr_arr [SLAVE_NUM];
  logic [SLAVE_NUM-1:0] grant_oh;
  logic [IW-1:0]        pick;
  logic                 pick_found;

  // Target bits for other master ports are only relevant to other instances.
  logic unused_wren;
  assign unused_wren = ^wren;

  for (genvar g = 0; g < SLAVE_NUM; g++) begin : g_slave
    assign elig[g]     = req[g] & wren[g*MASTER_NUM + MASTER_IDX];
    assign addr_arr[g] = addr[g*AWIDTH +: AWIDTH];
  end

  rr_pick #(
    .N  (SLAVE_NUM),
    .IW (IW)
  ) u_pick (
    .elig_i  (elig),
    .last_i  (last_q),
    .grant_o (pick),
    .found_o (pick_found)
  );

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // State register
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= IW'(SLAVE_NUM - 1);
      addr_q       <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_sel_q   <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_sel_q   <= resp_sel_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_sel_d   = resp_sel_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          last_d  = pick;
          addr_d  = addr_arr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ack) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Data arriving in the expiry cycle takes priority over the error.
        if (m_rvalid) begin
          resp_valid_d = 1'b1;
          resp_sel_d   = grant_oh;
          resp_data_d  = m_rdata;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          resp_valid_d = 1'b1;
          resp_sel_d   = grant_oh;
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. The request and pop are masked during reset so an ack seen in
  // the reset cycle can never pop a FIFO whose request is being abandoned.
  always_comb begin
    m_req      = (state_q == ISSUE) && !reset;
    rd_en      = (m_req && m_ack) ? grant_oh : '0;
    m_addr     = addr_q;
    resp_valid = resp_valid_q;
    resp_sel   = resp_sel_q;
    resp_data  = resp_data_q;
    resp_err   = resp_err_q;
  end

endmodule

// File: tb/tb_rd_req_arbiter.sv
module tb_rd_req_arbiter;
  localparam int S   = 2;
  localparam int M   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDX = 0;
  localparam int TO  = 8;

  logic          aclk = 1'b0;
  logic          reset;
  logic [S-1:0]  req;
  logic [S*AW-1:0] addr;
  logic [S*M-1:0]  wren;
  logic [S-1:0]  rd_en;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic          m_ack;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          resp_valid;
  logic [S-1:0]  resp_sel;
  logic [DW-1:0] resp_data;
  logic          resp_err;

  always #5 aclk = ~aclk;

  rd_req_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .SLAVE_NUM(S), .MASTER_NUM(M),
    .MASTER_IDX(IDX), .TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .reset(reset), .req(req), .addr(addr), .wren(wren),
    .rd_en(rd_en), .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .resp_valid(resp_valid),
    .resp_sel(resp_sel), .resp_data(resp_data), .resp_err(resp_err)
  );

  // Read request FIFOs, one queue per slave port.
  typedef struct {
    logic [AW-1:0] a;
    logic [M-1:0]  w;
  } ent_t;
  ent_t fq [S][$];

  // Reference model: a single transaction slot.
  //   ph 0 = no transaction, 1 = request offered, 2 = accepted, awaiting data
  int            ph, lg, cs, wc;
  logic [AW-1:0] ca;
  logic          e_rv, e_re;
  logic [S-1:0]  e_rs;
  logic [DW-1:0] e_rd;

  int checks, failures, cyc;

  // Snapshot of DUT outputs at the last compare point
  logic          s_mreq, s_rv, s_re;
  logic [AW-1:0] s_maddr;
  logic [S-1:0]  s_rden, s_rs;
  logic [DW-1:0] s_rd;
  int            s_cyc;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [AW-1:0] a, input logic [M-1:0] w);
    ent_t e;
    e.a = a;
    e.w = w;
    fq[s].push_back(e);
  endtask

  // One clock cycle: drive inputs (just after negedge), compare, advance model.
  task automatic step(input bit rst, input bit ack, input bit rv,
                      input logic [DW-1:0] rd, input bit other_pop);
    logic         e_mreq;
    logic [S-1:0] e_rden;
    int           pidx;
    bit           fnd;
    reset    = rst;
    m_ack    = ack;
    m_rvalid = rv;
    m_rdata  = rd;
    for (int i = 0; i < S; i++) begin
      req[i]            = fq[i].size() > 0;
      addr[i*AW +: AW]  = (fq[i].size() > 0) ? fq[i][0].a : '0;
      wren[i*M +: M]    = (fq[i].size() > 0) ? fq[i][0].w : '0;
    end
    #1;
    e_mreq = (ph == 1) && !rst;
    e_rden = (e_mreq && ack) ? S'(1 << cs) : '0;
    chk("m_req", m_req, e_mreq);
    chk("m_addr", m_addr, ca);
    chk("rd_en", rd_en, e_rden);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_sel", resp_sel, e_rs);
    chk("resp_data", resp_data, e_rd);
    chk("resp_err", resp_err, e_re);
    s_mreq = m_req; s_maddr = m_addr; s_rden = rd_en; s_rv = resp_valid;
    s_rs = resp_sel; s_rd = resp_data; s_re = resp_err; s_cyc = cyc;
    pidx = (e_rden != 0) ? cs : -1;
    if (rst) begin
      ph = 0; lg = S - 1; cs = 0; wc = 0; ca = '0;
      e_rv = 0; e_rs = '0; e_rd = '0; e_re = 0;
    end else begin
      e_rv = 0;
      case (ph)
        0: begin
          fnd = 0;
          for (int k = 1; k <= S; k++) begin
            int s;
            s = (lg + k) % S;
            if (!fnd && fq[s].size() > 0 && fq[s][0].w[IDX]) begin
              fnd = 1; cs = s; lg = s; ca = fq[s][0].a; ph = 1;
            end
          end
        end
        1: if (ack) begin ph = 2; wc = 0; end
        default: begin
          if (rv) begin
            e_rv = 1; e_rs = S'(1 << cs); e_rd = rd; e_re = 0; ph = 0;
          end else if (wc == TO - 1) begin
            e_rv = 1; e_rs = S'(1 << cs); e_rd = '0; e_re = 1; ph = 0;
          end else begin
            wc++;
          end
        end
      endcase
    end
    @(posedge aclk);
    if (pidx >= 0) void'(fq[pidx].pop_front());
    // Another master's arbiter drains heads not targeting this port.
    if (other_pop)
      for (int i = 0; i < S; i++)
        if (fq[i].size() > 0 && !fq[i][0].w[IDX] && $urandom_range(0, 3) == 0)
          void'(fq[i].pop_front());
    cyc++;
    @(negedge aclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nmreq, ackc, rcnt, nord, rv_cnt;
    bit got;
    int ord [4];
    checks = 0; failures = 0; cyc = 0;
    reset = 1; m_ack = 0; m_rvalid = 0; m_rdata = '0; req = '0; addr = '0; wren = '0;
    ph = 0; lg = S - 1; cs = 0; wc = 0; ca = '0;
    e_rv = 0; e_rs = '0; e_rd = '0; e_re = 0;
    @(negedge aclk);
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    chk("rst_mreq", s_mreq, 0);
    chk("rst_sel", s_rs, 2'b00);
    chk("rst_maddr", s_maddr, 0);

    // Single request from slave 1, ack on 2nd m_req cycle, data 3 cycles later
    push(1, 32'h1000, 2'b01);
    nmreq = 0; ackc = -100; rcnt = 0; got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      bit a, r;
      a = (ph == 1) && (nmreq == 1);
      r = (ph == 2) && (cyc == ackc + 3);
      step(0, a, r, 32'hDEADBEEF, 0);
      if (s_mreq) nmreq++;
      if (s_rden != 0) rcnt++;
      if (a) begin
        ackc = s_cyc;
        chk("t1_addr", s_maddr, 32'h1000);
        chk("t1_rden", s_rden, 2'b10);
      end
      if (s_rv) begin
        got = 1;
        chk("t1_sel", s_rs, 2'b10);
        chk("t1_data", s_rd, 32'hDEADBEEF);
        chk("t1_err", s_re, 0);
        chk("t1_lat", s_cyc - ackc, 4);
      end
    end
    chk("t1_seen", got, 1);
    chk("t1_rden_cnt", rcnt, 1);

    // Both slaves continuously eligible, immediate ack and data
    for (int i = 0; i < 3; i++) begin
      push(0, 32'h100 + i, 2'b01);
      push(1, 32'h200 + i, 2'b01);
    end
    nord = 0;
    for (int t = 0; t < 60 && (fq[0].size() + fq[1].size() > 0 || ph != 0); t++) begin
      step(0, 1, 1, $urandom, 0);
      if (s_rden != 0) begin
        chk("t2_onehot", $countones(s_rden), 1);
        if (nord < 4) ord[nord] = (s_rden == 2'b10) ? 1 : 0;
        nord++;
      end
    end
    chk("t2_count", nord, 6);
    chk("t2_g0", ord[0], 0);
    chk("t2_g1", ord[1], 1);
    chk("t2_g2", ord[2], 0);
    chk("t2_g3", ord[3], 1);

    // Slave 0 head targets the other master; only slave 1 may be served
    push(0, 32'h2000, 2'b10);
    push(1, 32'h3000, 2'b01);
    rcnt = 0; nmreq = 0;
    for (int t = 0; t < 20; t++) begin
      step(0, ph == 1, ph == 2, 32'h0BADF00D, 0);
      if (s_rden[0]) rcnt++;
      if (s_rden[1]) begin
        nmreq++;
        chk("t3_addr", s_maddr, 32'h3000);
      end
    end
    chk("t3_rden0", rcnt, 0);
    chk("t3_served", nmreq, 1);
    fq[0].delete();

    // Timeout: ack, then no data
    push(0, 32'h4000, 2'b01);
    ackc = -100; got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      step(0, ph == 1, 0, '0, 0);
      if (s_rden != 0) ackc = s_cyc;
      if (s_rv) begin
        got = 1;
        chk("t4_delay", s_cyc - ackc, TO + 1);
        chk("t4_err", s_re, 1);
        chk("t4_data", s_rd, 0);
        chk("t4_sel", s_rs, 2'b01);
      end
    end
    chk("t4_seen", got, 1);
    push(1, 32'h5000, 2'b01);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      step(0, ph == 1, ph == 2, 32'h12345678, 0);
      if (s_rv) begin
        got = 1;
        chk("t4b_err", s_re, 0);
        chk("t4b_data", s_rd, 32'h12345678);
      end
    end
    chk("t4b_seen", got, 1);

    // Data in the same cycle the timeout would expire
    push(0, 32'h6000, 2'b01);
    ackc = -100; got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      bit r;
      r = (ph == 2) && (cyc == ackc + TO);
      step(0, ph == 1, r, 32'hCAFEF00D, 0);
      if (s_rden != 0) ackc = s_cyc;
      if (s_rv) begin
        got = 1;
        chk("t5_err", s_re, 0);
        chk("t5_data", s_rd, 32'hCAFEF00D);
        chk("t5_delay", s_cyc - ackc, TO + 1);
      end
    end
    chk("t5_seen", got, 1);

    // Reset while the request is offered but not yet accepted
    push(1, 32'h7000, 2'b01);
    for (int t = 0; t < 10 && ph != 1; t++) step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    chk("t6_rden", s_rden, 0);
    step(0, 0, 0, '0, 0);
    chk("t6_mreq", s_mreq, 0);
    chk("t6_maddr", s_maddr, 0);
    chk("t6_rv", s_rv, 0);
    chk("t6_fifo", fq[1].size(), 1);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      step(0, ph == 1, ph == 2, 32'h77, 0);
      if (s_rden != 0) begin
        got = 1;
        chk("t6_readdr", s_maddr, 32'h7000);
        chk("t6_rden2", s_rden, 2'b10);
      end
    end
    chk("t6_reissued", got, 1);
    for (int t = 0; t < 5; t++) step(0, 0, 1, 32'h77, 0);

    // Randomized traffic
    rv_cnt = 0;
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int s;
        s = $urandom_range(0, S - 1);
        if (fq[s].size() < 4) push(s, $urandom, M'(1 << $urandom_range(0, M - 1)));
      end
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom, 1);
      if (s_rv) rv_cnt++;
    end
    checks++;
    if (rv_cnt < 50) begin
      failures++;
      $display("FAIL rand_responses got=%0d exp=>=50", rv_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
